// File: rtl/alu_pkg.sv
// Opcode encodings and result-flag bundle shared by the ALU pipeline and its core.
package alu_pkg;

    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_SUBU = 6'b100010;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_XOR  = 6'b100110;
    localparam logic [5:0] OP_SRA  = 6'b100111;
    localparam logic [5:0] OP_SRL  = 6'b101000;
    localparam logic [5:0] OP_NOR  = 6'b101001;
    localparam logic [5:0] OP_SLL  = 6'b000000;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_SLTU = 6'b101011;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } alu_flags_t;

    localparam int FLAGS_W = $bits(alu_flags_t);

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: operands + opcode in, result, flags and error out.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int SHAMT_W   = $clog2(DATA_SIZE)
) (
    input  logic [DATA_SIZE-1:0] a,
    input  logic [DATA_SIZE-1:0] b,
    input  logic [5:0]           opcode,
    output logic [DATA_SIZE-1:0] result,
    output alu_flags_t           flags,
    output logic                 err
);

    localparam int MSB = DATA_SIZE - 1;

    logic [DATA_SIZE:0]   sum;
    logic [DATA_SIZE:0]   diff;
    logic [SHAMT_W-1:0]   shamt;

    always_comb begin
        sum            = {1'b0, a} + {1'b0, b};
        diff           = {1'b0, a} - {1'b0, b};
        shamt          = a[SHAMT_W-1:0];
        result         = '0;
        err            = 1'b0;
        flags.carry    = 1'b0;
        flags.overflow = 1'b0;
        case (opcode)
            OP_ADD: begin
                result         = sum[MSB:0];
                flags.carry    = sum[DATA_SIZE];
                flags.overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUBU: begin
                // Extended-width MSB of the difference is the unsigned borrow.
                result         = diff[MSB:0];
                flags.carry    = diff[DATA_SIZE];
                flags.overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_SRA:  result = $signed(b) >>> shamt;
            OP_SRL:  result = b >> shamt;
            OP_SLL:  result = b << shamt;
            OP_SLT:  result = {{(DATA_SIZE-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result = {{(DATA_SIZE-1){1'b0}}, (a < b)};
            default: begin
                result = '1;
                err    = 1'b1;
            end
        endcase
        flags.zero     = (result == '0);
        flags.negative = result[MSB];
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: stage 1 holds operands, stage 2 holds result and flags.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int SHAMT_W   = $clog2(DATA_SIZE)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [DATA_SIZE-1:0] i_A,
    input  logic [DATA_SIZE-1:0] i_B,
    input  logic [5:0]           i_opcode,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATA_SIZE-1:0] o_output,
    output logic                 o_zero,
    output logic                 o_negative,
    output logic                 o_carry,
    output logic                 o_overflow,
    output logic                 o_err
);

    logic                 s1_valid;
    logic [DATA_SIZE-1:0] s1_a;
    logic [DATA_SIZE-1:0] s1_b;
    logic [5:0]           s1_op;

    logic                 s2_valid;
    logic [DATA_SIZE-1:0] s2_result;
    logic [FLAGS_W-1:0]   s2_flags;
    logic                 s2_err;

    logic [DATA_SIZE-1:0] core_result;
    alu_flags_t           core_flags;
    logic                 core_err;

    logic s1_adv;
    logic s2_adv;
    logic accept;

    alu_core #(
        .DATA_SIZE (DATA_SIZE),
        .SHAMT_W   (SHAMT_W)
    ) u_core (
        .a      (s1_a),
        .b      (s1_b),
        .opcode (s1_op),
        .result (core_result),
        .flags  (core_flags),
        .err    (core_err)
    );

    assign s2_adv  = !s2_valid || i_ready;
    assign s1_adv  = !s1_valid || s2_adv;
    // Gate with reset so the block never advertises readiness while held in reset.
    assign o_ready = i_rst_n && s1_adv;
    assign accept  = i_valid && o_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (s1_adv) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_a  <= i_A;
                s1_b  <= i_B;
                s1_op <= i_opcode;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
            s2_err    <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= core_result;
                s2_flags  <= core_flags;
                s2_err    <= core_err;
            end
        end
    end

    assign o_valid  = s2_valid;
    assign o_output = s2_result;
    assign {o_zero, o_negative, o_carry, o_overflow} = s2_flags;
    assign o_err    = s2_err;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (DATA_SIZE=8): vector table plus stall and reset sequences.
module tb_alu_pipe;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_A;
    logic [7:0] i_B;
    logic [5:0] i_opcode;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_output;
    logic       o_zero, o_negative, o_carry, o_overflow, o_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_pipe #(.DATA_SIZE(8)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_A        (i_A),
        .i_B        (i_B),
        .i_opcode   (i_opcode),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_output   (o_output),
        .o_zero     (o_zero),
        .o_negative (o_negative),
        .o_carry    (o_carry),
        .o_overflow (o_overflow),
        .o_err      (o_err)
    );

    // fl = {Z, N, C, V, ERR}
    typedef struct {
        logic [5:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [4:0] fl;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] observed();
        return {o_output, o_zero, o_negative, o_carry, o_overflow, o_err};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        i_ready  = 1'b1;
        i_valid  = 1'b1;
        i_A      = v.a;
        i_B      = v.b;
        i_opcode = v.op;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 6) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("latency[%0d]", idx), lat, 2);
        check($sformatf("vec[%0d]", idx), observed(), {v.res, v.fl});
        @(posedge clk);
        #1;
    endtask

    logic [5:0] s_op[4];
    logic [7:0] s_a[4];
    logic [7:0] s_b[4];
    logic [7:0] s_res[4];

    initial begin
        vecs[0]  = '{OP_ADD,  8'h7F, 8'h01, 8'h80, 5'b01010};
        vecs[1]  = '{OP_SUBU, 8'h00, 8'h01, 8'hFF, 5'b01100};
        vecs[2]  = '{OP_SUBU, 8'h05, 8'h05, 8'h00, 5'b10000};
        vecs[3]  = '{OP_SRA,  8'h0B, 8'h80, 8'hF0, 5'b01000};
        vecs[4]  = '{OP_SRL,  8'h0B, 8'h80, 8'h10, 5'b00000};
        vecs[5]  = '{OP_SLT,  8'hFF, 8'h01, 8'h01, 5'b00000};
        vecs[6]  = '{OP_SLTU, 8'hFF, 8'h01, 8'h00, 5'b10000};
        vecs[7]  = '{OP_ADD,  8'hFF, 8'h01, 8'h00, 5'b10100};
        vecs[8]  = '{OP_AND,  8'hF0, 8'h3C, 8'h30, 5'b00000};
        vecs[9]  = '{OP_OR,   8'hF0, 8'h0F, 8'hFF, 5'b01000};
        vecs[10] = '{OP_XOR,  8'hFF, 8'h0F, 8'hF0, 5'b01000};
        vecs[11] = '{OP_NOR,  8'hF0, 8'h0F, 8'h00, 5'b10000};
        vecs[12] = '{OP_SLL,  8'h02, 8'h81, 8'h04, 5'b00000};
        vecs[13] = '{OP_SUBU, 8'h80, 8'h01, 8'h7F, 5'b00010};
        vecs[14] = '{6'b111111, 8'h12, 8'h34, 8'hFF, 5'b01001};
        vecs[15] = '{OP_ADD,  8'h01, 8'h01, 8'h02, 5'b00000};

        s_op  = '{OP_ADD, OP_SUBU, OP_XOR, OP_AND};
        s_a   = '{8'h10, 8'h50, 8'hAA, 8'hF0};
        s_b   = '{8'h20, 8'h08, 8'h55, 8'h3C};
        s_res = '{8'h30, 8'h48, 8'hFF, 8'h30};

        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b1;
        i_A      = '0;
        i_B      = '0;
        i_opcode = '0;
        #12;
        check("reset_outputs", {o_valid, o_ready, observed()}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", o_ready, 1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Four back-to-back ops with downstream stalled in cycles 1..3.
        begin
            int nacc = 0;
            int nret = 0;
            logic acc, ret;
            for (int cyc = 0; cyc < 20; cyc++) begin
                @(negedge clk);
                i_ready = !(cyc >= 1 && cyc <= 3);
                if (nacc < 4) begin
                    i_valid  = 1'b1;
                    i_opcode = s_op[nacc];
                    i_A      = s_a[nacc];
                    i_B      = s_b[nacc];
                end else begin
                    i_valid = 1'b0;
                end
                #1;
                if (cyc == 2 || cyc == 3) begin
                    check($sformatf("stall_ready_c%0d", cyc), o_ready, 0);
                    check($sformatf("stall_hold_c%0d", cyc), {o_valid, o_output}, {1'b1, s_res[0]});
                end
                acc = i_valid && o_ready;
                ret = o_valid && i_ready;
                if (ret) begin
                    if (nret < 4) check($sformatf("stall_res[%0d]", nret), o_output, s_res[nret]);
                    else check("stall_extra_result", 1, 0);
                    nret++;
                end
                @(posedge clk);
                if (acc) nacc++;
            end
            check("stall_retired", nret, 4);
            check("stall_accepted", nacc, 4);
        end

        // Reset asserted mid-cycle with two ops in flight.
        @(negedge clk);
        i_ready  = 1'b0;
        i_valid  = 1'b1;
        i_opcode = OP_ADD;
        i_A      = 8'h7F;
        i_B      = 8'h01;
        @(negedge clk);
        i_opcode = OP_SUBU;
        i_A      = 8'h00;
        i_B      = 8'h01;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        check("inflight_valid", o_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {o_valid, o_ready, observed()}, '0);
        @(negedge clk);
        rst_n   = 1'b1;
        i_ready = 1'b1;
        #1;
        check("ready_after_rerelease", o_ready, 1);
        begin
            logic stale = 1'b0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (o_valid) stale = 1'b1;
            end
            check("no_stale_result", stale, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter DATA_SIZE, default 8, operand/result width in bits (legal range 4..64).
REQ-002 Parameter SHAMT_W, default $clog2(DATA_SIZE), number of i_A LSBs used as shift amount.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_valid  input  1  upstream presents an operation this cycle.
REQ-006 o_ready  output  1  block accepts an operation this cycle.
REQ-007 i_A  input  DATA_SIZE  operand A (shift amount for shift ops).
REQ-008 i_B  input  DATA_SIZE  operand B (shifted value for shift ops).
REQ-009 i_opcode  input  6  operation select.
REQ-010 o_valid  output  1  result and flags valid.
REQ-011 i_ready  input  1  downstream accepts result this cycle.
REQ-012 o_output  output  DATA_SIZE  result.
REQ-013 o_zero, o_negative, o_carry, o_overflow  output  1 each  result flags.
REQ-014 o_err  output  1  result came from an unsupported opcode.

Function
REQ-015 Opcodes: ADD 100000, SUBU 100010, AND 100100, OR 100101, XOR 100110, SRA 100111, SRL 101000, NOR 101001, SLL 000000, SLT 101010, SLTU 101011.
REQ-016 Input handshake: operation accepted on a cycle where i_valid && o_ready.
REQ-017 Output handshake: result retired on a cycle where o_valid && i_ready; o_output, flags, o_err hold stable while o_valid && !i_ready.
REQ-018 Two-stage pipeline: stage 1 registers operands/opcode; stage 2 registers result/flags; latency accept-to-o_valid exactly 2 cycles with i_ready held high.
REQ-019 A stage advances when it is empty or the stage after it advances in the same cycle; o_ready = !s1_valid || s1 advances.
REQ-020 Sustained throughput one operation per cycle when i_ready stays high; no bubbles inserted.
REQ-021 Full pipeline with i_ready low: o_ready low, no operand dropped or duplicated; accept and retire in the same cycle permitted.
REQ-022 ADD/SUBU: DATA_SIZE-bit two's-complement result, wraps modulo 2^DATA_SIZE.
REQ-023 o_carry: ADD = carry-out of bit DATA_SIZE-1; SUBU = borrow (1 when A < B unsigned); 0 for all other ops.
REQ-024 o_overflow: signed overflow for ADD/SUBU only; 0 otherwise.
REQ-025 Shifts use i_A[SHAMT_W-1:0] only; SRL zero-fills, SRA sign-fills from i_B MSB, SLL zero-fills.
REQ-026 SLT/SLTU: result 1 (zero-extended) when A < B signed/unsigned, else 0.
REQ-027 o_zero = (o_output == 0); o_negative = o_output[DATA_SIZE-1]; both for every op including illegal.
REQ-028 Unsupported opcode: o_output all ones, o_err 1, o_carry/o_overflow 0; pipeline flow unaffected.

Reset
REQ-029 i_rst_n low clears both stage valid bits immediately, regardless of i_clk.
REQ-030 During reset: o_valid 0, o_ready 0, o_output 0, all flags 0, o_err 0.
REQ-031 Operations in flight when reset asserts are discarded; first accept possible on first rising edge after i_rst_n deasserts, o_ready 1 from that edge.

Structure
REQ-032 Package alu_pkg holds opcode localparams and a flags struct/bundle width constant; alu_pipe imports it.
REQ-033 One combinational sub-module alu_core (operands + opcode in, result + flags + err out) instantiated in stage 2; pipeline/handshake logic stays in alu_pipe.

Verification (DATA_SIZE=8)
REQ-034 ADD A=0x7F B=0x01, i_ready=1 -> 2 cycles later o_output=0x80, N=1 V=1 C=0 Z=0.
REQ-035 SUBU A=0x00 B=0x01 -> 0xFF, C=1 N=1 V=0; SUBU 0x05-0x05 -> 0x00, Z=1 C=0.
REQ-036 SRA A=0x0B B=0x80 (shamt 3) -> 0xF0; SRL same -> 0x10; SLT A=0xFF B=0x01 -> 0x01, SLTU -> 0x00.
REQ-037 Back-to-back 4 ops with i_ready low for 3 cycles mid-stream -> o_ready drops once 2 ops held, outputs stable, all 4 results appear in order, none lost.
REQ-038 Opcode 111111 -> o_output 0xFF, o_err 1; next legal op has o_err 0.
REQ-039 Assert i_rst_n low between edges with 2 ops in flight -> o_valid 0 immediately; after release no stale result appears.
